// File: rtl/lvds_check_pkg.sv
// Shared types for the LVDS return-line checker: line count, channel index and FSM states.
package lvds_check_pkg;

    localparam int NUM_LINES = 8;

    typedef logic [2:0] lvds_ch_t;

    typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, REPORT} chk_state_t;

endpackage

// File: rtl/lvds_edge_counter.sv
// Purpose: synchronise one async LVDS line, detect rising edges, count them with saturation.
// Latency: SYNC_STAGES+1 cycles from line change to count update.
// Backpressure: none; clr_i has priority over en_i.
module lvds_edge_counter
    import lvds_check_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             line_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   rise;

    // prev_q tracks the synchronised level even while counting is disabled
    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && rise && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/lvds_line_checker.sv
// Purpose: count rising edges on 8 LVDS return lines and check only ch_sel toggles (LVDS_AUTO_SCAN_EN scans 0..7).
// Latency: done SETTLE_CYC+WINDOW_CYC+2 cycles after start is sampled (scan: 8*(SETTLE_CYC+WINDOW_CYC+1)+1).
// Backpressure: none; start is ignored unless the FSM is idle.
module lvds_line_checker
    import lvds_check_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int WINDOW_CYC  = 1000,
    parameter int MIN_EDGES   = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk_100Mz,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       j,
    input  logic [7:0]       lvds_in,
    output logic [2:0]       ch_sel,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       fail_mask,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [7:0]       pass_vec
);

    localparam int TMR_MAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW_CYC - 1);

    logic [1:0]           rst_sync_q;
    logic                 rst_n;
    chk_state_t           state_q;
    logic [TMR_W-1:0]     timer_q;
    logic                 start_q;
    lvds_ch_t             ch_sel_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 pass_q;
    logic [NUM_LINES-1:0] fail_mask_q;
    logic [CNT_W-1:0]     edge_cnt_q;
    logic [NUM_LINES-1:0] pass_vec_q;
    logic [CNT_W-1:0]     cnt [NUM_LINES];
    logic                 cnt_clr;
    logic                 cnt_en;
    logic [NUM_LINES-1:0] fail_d;
    logic                 pass_d;
    logic [NUM_LINES-1:0] pv_next;
    logic                 pass_out;
    lvds_ch_t             first_ch;
`ifdef LVDS_AUTO_SCAN_EN
    logic [NUM_LINES-1:0] pv_acc_q;
    logic                 unused_j;
    assign unused_j = ^j;
    assign first_ch = '0;
`else
    lvds_ch_t             j_q;
    assign first_ch = j_q;
`endif

    // Asserts asynchronously, releases two edges after reset_n rises
    always_ff @(posedge clk_100Mz or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign cnt_clr = (state_q == SETTLE) || ((state_q == IDLE) && start_q);
    assign cnt_en  = (state_q == MEASURE);

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_line
        lvds_edge_counter #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W)
        ) u_cnt (
            .clk_i   (clk_100Mz),
            .rst_n_i (rst_n),
            .line_i  (lvds_in[g]),
            .clr_i   (cnt_clr),
            .en_i    (cnt_en),
            .cnt_o   (cnt[g])
        );
    end

    always_comb begin
        fail_d = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (lvds_ch_t'(i) == ch_sel_q) begin
                fail_d[i] = (cnt[i] < CNT_W'(MIN_EDGES));
            end else begin
                fail_d[i] = (cnt[i] != '0);
            end
        end
        pass_d = (fail_d == '0);
`ifdef LVDS_AUTO_SCAN_EN
        pv_next = pv_acc_q;
`else
        pv_next = '0;
`endif
        pv_next[ch_sel_q] = pass_d;
`ifdef LVDS_AUTO_SCAN_EN
        pass_out = &pv_next;
`else
        pass_out = pass_d;
`endif
    end

    always_ff @(posedge clk_100Mz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            start_q     <= 1'b0;
            ch_sel_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            edge_cnt_q  <= '0;
            pass_vec_q  <= '0;
`ifdef LVDS_AUTO_SCAN_EN
            pv_acc_q    <= '0;
`else
            j_q         <= '0;
`endif
        end else begin
            // start is only captured while idle, so pulses during a run never queue
            start_q <= start && (state_q == IDLE);
`ifndef LVDS_AUTO_SCAN_EN
            j_q     <= j;
`endif
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_q) begin
                        state_q  <= SETTLE;
                        timer_q  <= '0;
                        busy_q   <= 1'b1;
                        ch_sel_q <= first_ch;
`ifdef LVDS_AUTO_SCAN_EN
                        pv_acc_q <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (timer_q == SETTLE_LAST) begin
                        state_q <= MEASURE;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                MEASURE: begin
                    if (timer_q == WINDOW_LAST) begin
                        state_q <= REPORT;
                        timer_q <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                REPORT: begin
                    timer_q <= '0;
`ifdef LVDS_AUTO_SCAN_EN
                    pv_acc_q <= pv_next;
                    if (ch_sel_q != 3'd7) begin
                        state_q  <= SETTLE;
                        ch_sel_q <= ch_sel_q + 3'd1;
                    end else begin
`else
                    begin
`endif
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= pass_out;
                        fail_mask_q <= fail_d;
                        edge_cnt_q  <= cnt[ch_sel_q];
                        pass_vec_q  <= pv_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ch_sel    = ch_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_mask_q;
    assign edge_cnt  = edge_cnt_q;
    assign pass_vec  = pass_vec_q;

endmodule

// File: tb/tb_lvds_line_checker.sv
// Directed bench for lvds_line_checker: a window-level edge model predicts results, compared every cycle.
module tb_lvds_line_checker;

    localparam int S  = 16;
    localparam int W  = 1000;
    localparam int CW = 16;
`ifdef LVDS_AUTO_SCAN_EN
    localparam int LAT = 8 * (S + W + 1) + 1;
`else
    localparam int LAT = S + W + 2;
`endif
    localparam longint P = 10;

    logic          clk_100Mz = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic [2:0]    j         = 3'd0;
    logic [7:0]    lvds_in   = 8'h00;
    logic [2:0]    ch_sel;
    logic          busy;
    logic          done;
    logic          pass;
    logic [7:0]    fail_mask;
    logic [CW-1:0] edge_cnt;
    logic [7:0]    pass_vec;

    int     checks   = 0;
    int     failures = 0;
    int     done_cnt = 0;
    logic   cmp_on   = 1'b0;
    longint t_start  = -1;

    // model state: pending prediction for the running check, and held results
    logic [2:0] exp_ch = 3'd0, pend_ch = 3'd0;
    logic [7:0] m_fail = 8'h00, m_pv = 8'h00, p_fail = 8'h00, p_pv = 8'h00;
    logic       m_pass = 1'b0, p_pass = 1'b0;
    int         m_lo = 0, m_hi = 0, p_lo = 0, p_hi = 0;

    logic [7:0] tog_mask = 8'h00;
    logic [7:0] stat_lvl = 8'h00;
    logic       sq = 1'b0;
    int         ph = 0;

    lvds_line_checker #(
        .SYNC_STAGES (2),
        .SETTLE_CYC  (S),
        .WINDOW_CYC  (W),
        .MIN_EDGES   (1),
        .CNT_W       (CW)
    ) dut (
        .clk_100Mz (clk_100Mz),
        .reset_n   (reset_n),
        .start     (start),
        .j         (j),
        .lvds_in   (lvds_in),
        .ch_sel    (ch_sel),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_mask (fail_mask),
        .edge_cnt  (edge_cnt),
        .pass_vec  (pass_vec)
    );

    always #5 clk_100Mz = ~clk_100Mz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp_v);
        end
    endtask

    task automatic check_rng(input string name, input logic [63:0] act, input int lo, input int hi);
        checks++;
        if ($isunknown(act) || act < 64'(lo) || act > 64'(hi)) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d..%0d", name, $time, act, lo, hi);
        end
    endtask

    // 10-cycle square wave; a 1000-cycle window sees 100 rising edges
    initial forever begin
        @(posedge clk_100Mz);
        #1;
        ph = ph + 1;
        if (ph == 5) begin
            ph = 0;
            sq = ~sq;
        end
`ifdef LVDS_AUTO_SCAN_EN
        lvds_in = (sq && ch_sel != 3'd6) ? (8'd1 << ch_sel) : 8'h00;
`else
        lvds_in = (sq ? tog_mask : 8'h00) | stat_lvl;
`endif
    end

    // Predict the report from which lines toggle during the window
    task automatic model_arm(input logic [2:0] jj);
        int c;
        pend_ch = jj;
        p_fail  = 8'h00;
        p_pv    = 8'h00;
`ifdef LVDS_AUTO_SCAN_EN
        for (int k = 0; k < 8; k++) p_pv[k] = (k != 6);
        p_pass = &p_pv;
        p_lo   = W / 10 - 1;
        p_hi   = W / 10 + 1;
`else
        for (int i = 0; i < 8; i++) begin
            c = tog_mask[i] ? W / 10 : 0;
            p_fail[i] = (i == int'(jj)) ? (c < 1) : (c != 0);
        end
        p_pass     = (p_fail == 8'h00);
        p_pv[jj]   = p_pass;
        p_lo       = tog_mask[jj] ? W / 10 - 1 : 0;
        p_hi       = tog_mask[jj] ? W / 10 + 1 : 0;
`endif
    endtask

    task automatic do_start(input logic [2:0] jj, output longint ts);
        @(posedge clk_100Mz);
        #1;
        start = 1'b1;
        j     = jj;
        @(posedge clk_100Mz);
        ts = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic run_chk(input logic [2:0] jj, output longint ts);
        model_arm(jj);
        do_start(jj, ts);
        t_start = ts;
    endtask

    always @(negedge clk_100Mz) begin
        longint tn;
        logic   ed, eb;
        if (reset_n && cmp_on) begin
            tn = $time;
            ed = (t_start >= 0) && (tn == t_start + LAT * P + 5);
            eb = (t_start >= 0) && (tn > t_start + P) && (tn < t_start + LAT * P);
            if (t_start >= 0 && tn == t_start + P + 5) exp_ch = pend_ch;
            if (ed) begin
                m_fail = p_fail;
                m_pv   = p_pv;
                m_pass = p_pass;
                m_lo   = p_lo;
                m_hi   = p_hi;
            end
            check("done", done, ed);
            check("busy", busy, eb);
`ifndef LVDS_AUTO_SCAN_EN
            check("ch_sel", ch_sel, exp_ch);
`endif
            check("fail_mask", fail_mask, m_fail);
            check("pass", pass, m_pass);
            check("pass_vec", pass_vec, m_pv);
            check_rng("edge_cnt", edge_cnt, m_lo, m_hi);
            if (done) done_cnt++;
            if (ed) t_start = -1;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, busy, 0);
        check({tag, " done"}, done, 0);
        check({tag, " pass"}, pass, 0);
        check({tag, " fail_mask"}, fail_mask, 0);
        check({tag, " edge_cnt"}, edge_cnt, 0);
        check({tag, " pass_vec"}, pass_vec, 0);
        check({tag, " ch_sel"}, ch_sel, 0);
    endtask

    task automatic model_reset();
        t_start = -1;
        exp_ch  = 3'd0;
        m_fail  = 8'h00;
        m_pv    = 8'h00;
        m_pass  = 1'b0;
        m_lo    = 0;
        m_hi    = 0;
    endtask

    initial begin
        longint ts;
        int     d0;

        repeat (3) @(posedge clk_100Mz);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (5) @(posedge clk_100Mz);
        cmp_on = 1'b1;

`ifdef LVDS_AUTO_SCAN_EN
        // T6: full scan, line 6 disconnected
        d0 = done_cnt;
        run_chk(3'd5, ts);
        repeat (LAT + 5) @(posedge clk_100Mz);
        #1;
        check("T6 done count", done_cnt - d0, 1);
        check("T6 ch_sel", ch_sel, 7);
        check("T6 pass_vec", pass_vec, 8'hBF);
        check("T6 pass", pass, 0);
        check("T6 fail_mask", fail_mask, 8'h00);
        check_rng("T6 edge_cnt", edge_cnt, 99, 101);
`else
        // T2: nominal, line 3 toggles
        tog_mask = 8'h08;
        d0 = done_cnt;
        run_chk(3'd3, ts);
        repeat (LAT + 5) @(posedge clk_100Mz);
        #1;
        check("T2 done count", done_cnt - d0, 1);
        check("T2 fail_mask", fail_mask, 8'h00);
        check("T2 pass", pass, 1);
        check("T2 pass_vec", pass_vec, 8'h08);
        check_rng("T2 edge_cnt", edge_cnt, 99, 101);

        // T3: crosstalk on line 5
        tog_mask = 8'h28;
        run_chk(3'd3, ts);
        repeat (LAT + 5) @(posedge clk_100Mz);
        #1;
        check("T3 fail_mask", fail_mask, 8'h20);
        check("T3 pass", pass, 0);
        check("T3 pass_vec", pass_vec, 8'h00);
        check_rng("T3 edge_cnt", edge_cnt, 99, 101);

        // T4: selected line stuck high
        tog_mask = 8'h00;
        stat_lvl = 8'h01;
        repeat (10) @(posedge clk_100Mz);
        run_chk(3'd0, ts);
        repeat (LAT + 5) @(posedge clk_100Mz);
        #1;
        check("T4 edge_cnt", edge_cnt, 0);
        check("T4 fail_mask", fail_mask, 8'h01);
        check("T4 pass", pass, 0);

        // T5: start pulses during SETTLE, MEASURE and REPORT are ignored
        stat_lvl = 8'h00;
        tog_mask = 8'h08;
        repeat (10) @(posedge clk_100Mz);
        d0 = done_cnt;
        run_chk(3'd3, ts);
        begin
            longint tdummy;
            repeat (4) @(posedge clk_100Mz);
            do_start(3'd5, tdummy);
            repeat (500) @(posedge clk_100Mz);
            do_start(3'd6, tdummy);
            while ($time < ts + (LAT - 1) * P) @(posedge clk_100Mz);
            #1;
            start = 1'b1;
            j     = 3'd7;
            @(posedge clk_100Mz);
            #1;
            start = 1'b0;
        end
        repeat (LAT + 20) @(posedge clk_100Mz);
        #1;
        check("T5 done count", done_cnt - d0, 1);
        check("T5 ch_sel", ch_sel, 3);
        check("T5 pass_vec", pass_vec, 8'h08);

        // T1: reset mid-run clears everything at once, no done afterwards
        d0 = done_cnt;
        run_chk(3'd3, ts);
        repeat (300) @(posedge clk_100Mz);
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all_zero("T1");
        @(posedge clk_100Mz);
        #1;
        reset_n = 1'b1;
        repeat (LAT + 20) @(posedge clk_100Mz);
        #1;
        check("T1 busy", busy, 0);
        check("T1 done count", done_cnt - d0, 0);
`endif

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
